// File: rtl/led_matrix_scan_ctrl.sv
// Column scan sequencer for an 8x8 LED matrix: blanking gap, per-column PWM on
// the row drive, and frame-aligned display buffer swaps via a req/ack handshake.
module led_matrix_scan_ctrl #(
    parameter int NCOLS        = 8,
    parameter int DWELL_W      = 16,
    parameter int BRIGHT_W     = 4,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [DWELL_W-1:0]         dwell,
    input  logic [BRIGHT_W-1:0]        brightness,
    input  logic                       swap_req,
    output logic                       swap_ack,
    output logic                       buf_sel,
    output logic [$clog2(NCOLS)-1:0]   col_idx,
    output logic [NCOLS-1:0]           col_en,
    output logic                       row_oe,
    output logic                       frame_start
);

    localparam int CIDX_W = $clog2(NCOLS);
    localparam int PROD_W = DWELL_W + BRIGHT_W;
    localparam logic [DWELL_W-1:0] BLANK_LAST = DWELL_W'(BLANK_CYCLES - 1);
    localparam logic [CIDX_W-1:0]  LAST_COL   = CIDX_W'(NCOLS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

    state_t               state, state_nxt;
    logic [DWELL_W-1:0]   cnt, cnt_nxt;
    logic [DWELL_W:0]     cnt_inc;
    logic [DWELL_W-1:0]   eff_q, bc_q;
    logic [DWELL_W-1:0]   eff_in, bc_in;
    logic [PROD_W-1:0]    prod;
    logic [CIDX_W-1:0]    col_idx_nxt;
    logic [NCOLS-1:0]     col_en_nxt;
    logic                 row_oe_nxt, frame_start_nxt, swap_ack_nxt, buf_sel_nxt;
    logic                 req_used, req_used_nxt;
    logic                 blank_done, on_done, last_col, do_swap;

    // Column timing is taken from the inputs at the BLANK->ON edge.
    assign eff_in  = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign prod    = {{BRIGHT_W{1'b0}}, eff_in} * {{DWELL_W{1'b0}}, brightness};
    assign bc_in   = (&brightness) ? eff_in : DWELL_W'(prod >> BRIGHT_W);

    assign cnt_inc    = {1'b0, cnt} + (DWELL_W + 1)'(1);
    assign blank_done = (state == BLANK) && (cnt == BLANK_LAST);
    assign on_done    = (state == ON) && (cnt == eff_q - DWELL_W'(1));
    assign last_col   = (col_idx == LAST_COL);
    // A held request swaps once; it must drop before it can swap again.
    assign do_swap    = swap_req && !req_used &&
                        ((state == IDLE) || (ena && on_done && last_col));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            col_idx     <= '0;
            col_en      <= '0;
            row_oe      <= 1'b0;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
            buf_sel     <= 1'b0;
            req_used    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            col_idx     <= col_idx_nxt;
            col_en      <= col_en_nxt;
            row_oe      <= row_oe_nxt;
            frame_start <= frame_start_nxt;
            swap_ack    <= swap_ack_nxt;
            buf_sel     <= buf_sel_nxt;
            req_used    <= req_used_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (ena && blank_done) begin
            eff_q <= eff_in;
            bc_q  <= bc_in;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!ena) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = BLANK;
                BLANK:   if (blank_done) state_nxt = ON;
                ON:      if (on_done) state_nxt = BLANK;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_nxt         = cnt + DWELL_W'(1);
        col_idx_nxt     = col_idx;
        col_en_nxt      = '0;
        row_oe_nxt      = 1'b0;
        frame_start_nxt = 1'b0;
        if (!ena) begin
            cnt_nxt     = '0;
            col_idx_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt         = '0;
                    col_idx_nxt     = '0;
                    frame_start_nxt = 1'b1;
                end
                BLANK: begin
                    if (blank_done) begin
                        cnt_nxt             = '0;
                        col_en_nxt[col_idx] = 1'b1;
                        row_oe_nxt          = (bc_in != '0);
                    end
                end
                ON: begin
                    if (on_done) begin
                        cnt_nxt         = '0;
                        col_idx_nxt     = last_col ? '0 : col_idx + CIDX_W'(1);
                        frame_start_nxt = last_col;
                    end else begin
                        col_en_nxt[col_idx] = 1'b1;
                        row_oe_nxt          = (cnt_inc < {1'b0, bc_q});
                    end
                end
                default: cnt_nxt = '0;
            endcase
        end
        swap_ack_nxt = do_swap;
        buf_sel_nxt  = buf_sel ^ do_swap;
        if (!swap_req)
            req_used_nxt = 1'b0;
        else if (do_swap)
            req_used_nxt = 1'b1;
        else
            req_used_nxt = req_used;
    end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Self-checking bench for led_matrix_scan_ctrl: a column-schedule reference model
// produces the expected output stream, plus scenario checks for swaps and aborts.
module tb_led_matrix_scan_ctrl;

    localparam int BLANK = 4;

    logic        clk = 1'b0;
    logic        rst_n, ena, swap_req;
    logic [15:0] dwell;
    logic [3:0]  brightness;
    logic        swap_ack, buf_sel, row_oe, frame_start;
    logic [2:0]  col_idx;
    logic [7:0]  col_en;

    int checks = 0;
    int errors = 0;

    led_matrix_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .dwell(dwell), .brightness(brightness),
        .swap_req(swap_req), .swap_ack(swap_ack), .buf_sel(buf_sel), .col_idx(col_idx),
        .col_en(col_en), .row_oe(row_oe), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Observed output vector, same packing as model records.
    logic [14:0] obs;
    assign obs = {col_en, row_oe, col_idx, frame_start, swap_ack, buf_sel};

    // Reference model: expands each column into its blank and on records.
    logic [14:0] m_q[$];
    int          m_col;
    bit          m_on;
    logic        m_buf;
    bit          m_used;

    task automatic model_start();
        m_q.delete();
        m_col  = 0;
        m_on   = 0;
        m_used = 0;
    endtask

    task automatic model_next(output logic [14:0] e);
        int eff, bc;
        logic fs, ack;
        logic [7:0] oh;
        if (m_q.size() == 0) begin
            if (!m_on) begin
                fs  = (m_col == 0);
                ack = 1'b0;
                if (fs && swap_req && !m_used) begin
                    m_buf  = ~m_buf;
                    ack    = 1'b1;
                    m_used = 1;
                end
                for (int i = 0; i < BLANK; i++)
                    m_q.push_back({8'h00, 1'b0, 3'(m_col), fs && (i == 0), ack && (i == 0), m_buf});
                m_on = 1;
            end else begin
                eff = (dwell == 16'd0) ? 1 : int'(dwell);
                bc  = (brightness == 4'hF) ? eff : (eff * int'(brightness)) / 16;
                oh  = 8'b1 << m_col;
                for (int k = 0; k < eff; k++)
                    m_q.push_back({oh, k < bc, 3'(m_col), 1'b0, 1'b0, m_buf});
                m_col = (m_col + 1) % 8;
                m_on  = 0;
            end
        end
        if (!swap_req) m_used = 0;
        e = m_q.pop_front();
    endtask

    task automatic go_idle();
        ena      = 1'b0;
        swap_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; swap_req = 1'b0; dwell = 16'd10; brightness = 4'hF;
        m_buf = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 15'h0) begin
            errors++;
            $display("FAIL reset_hold got %h exp %h", obs, 15'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 15'h0) begin
                errors++;
                $display("FAIL idle_dark cyc %0d got %h exp %h", i, obs, 15'h0);
            end
        end
    endtask

    task automatic test_scan_fixed();
        logic [14:0] e;
        int prev = -1, nfs = 0;
        go_idle();
        dwell = 16'd10; brightness = 4'hF;
        model_start();
        ena = 1'b1;
        for (int cyc = 0; cyc < 241; cyc++) begin
            @(negedge clk);
            model_next(e);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL scan t=%0t got %h exp %h", $time, obs, e);
            end
            if (frame_start === 1'b1) begin
                nfs++;
                if (prev >= 0) begin
                    checks++;
                    if (cyc - prev != 112) begin
                        errors++;
                        $display("FAIL frame_period got %0d exp 112", cyc - prev);
                    end
                end
                prev = cyc;
            end
        end
        checks++;
        if (nfs != 3) begin
            errors++;
            $display("FAIL frame_count got %0d exp 3", nfs);
        end
    endtask

    task automatic test_pwm();
        logic [14:0] e;
        int dw[3]   = '{16, 16, 0};
        int br[3]   = '{4, 0, 15};
        int oe_n[3] = '{32, 0, 8};
        int on_n[3] = '{128, 128, 8};
        int oe_cnt, on_cnt, len;
        for (int t = 0; t < 3; t++) begin
            go_idle();
            dwell = 16'(dw[t]); brightness = 4'(br[t]);
            len = 8 * (BLANK + ((dw[t] == 0) ? 1 : dw[t]));
            model_start();
            ena = 1'b1;
            oe_cnt = 0; on_cnt = 0;
            for (int cyc = 0; cyc < len; cyc++) begin
                @(negedge clk);
                model_next(e);
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL pwm%0d t=%0t got %h exp %h", t, $time, obs, e);
                end
                if (row_oe === 1'b1) oe_cnt++;
                if (col_en !== 8'h00) on_cnt++;
            end
            checks++;
            if (oe_cnt != oe_n[t] || on_cnt != on_n[t]) begin
                errors++;
                $display("FAIL pwm_counts%0d got oe=%0d on=%0d exp oe=%0d on=%0d",
                         t, oe_cnt, on_cnt, oe_n[t], on_n[t]);
            end
        end
    endtask

    task automatic test_swap_midframe();
        logic [14:0] e;
        bit set = 0;
        int acks = 0;
        go_idle();
        dwell = 16'd3; brightness = 4'd8;
        model_start();
        ena = 1'b1;
        for (int cyc = 0; cyc < 230; cyc++) begin
            @(negedge clk);
            model_next(e);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL swap_mid t=%0t got %h exp %h", $time, obs, e);
            end
            if (swap_ack === 1'b1) begin
                acks++;
                checks++;
                if (frame_start !== 1'b1 || col_idx !== 3'd0 || buf_sel !== 1'b1) begin
                    errors++;
                    $display("FAIL swap_align got fs=%b col=%0d buf=%b exp fs=1 col=0 buf=1",
                             frame_start, col_idx, buf_sel);
                end
            end
            if (!set && col_idx === 3'd3 && col_en !== 8'h00) begin
                swap_req = 1'b1;
                set = 1;
            end
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL swap_ack_count got %0d exp 1", acks);
        end
        go_idle();
    endtask

    task automatic test_abort();
        logic [14:0] e;
        bit found = 0;
        go_idle();
        dwell = 16'd6; brightness = 4'd8;
        model_start();
        ena = 1'b1;
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            @(negedge clk);
            model_next(e);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL abort_run t=%0t got %h exp %h", $time, obs, e);
            end
            if (col_idx === 3'd5 && col_en !== 8'h00) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach got none exp column 5 on");
        end
        ena = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== {8'h00, 1'b0, 3'd0, 1'b0, 1'b0, m_buf}) begin
            errors++;
            $display("FAIL abort_dark got %h exp %h", obs, {8'h00, 1'b0, 3'd0, 1'b0, 1'b0, m_buf});
        end
        @(negedge clk);
        model_start();
        ena = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            model_next(e);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL restart t=%0t got %h exp %h", $time, obs, e);
            end
        end
        checks++;
        if (col_en === 8'h00 || m_buf !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got col_en=%h buf=%b exp nonzero and 1", col_en, m_buf);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 15'h0) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", obs, 15'h0);
        end
        m_buf = 1'b0;
        ena = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_swap_idle();
        swap_req = 1'b1;
        @(negedge clk);
        m_buf = ~m_buf;
        checks++;
        if ({swap_ack, buf_sel} !== {1'b1, m_buf}) begin
            errors++;
            $display("FAIL idle_swap got ack=%b buf=%b exp ack=1 buf=%b", swap_ack, buf_sel, m_buf);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({swap_ack, buf_sel} !== {1'b0, m_buf}) begin
                errors++;
                $display("FAIL idle_hold got ack=%b buf=%b exp ack=0 buf=%b", swap_ack, buf_sel, m_buf);
            end
        end
        swap_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [14:0] e;
        go_idle();
        dwell = 16'($urandom_range(0, 12));
        brightness = 4'($urandom_range(0, 15));
        model_start();
        ena = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            model_next(e);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL random t=%0t got %h exp %h", $time, obs, e);
            end
            if ($urandom_range(0, 7) == 0) dwell = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) swap_req = ~swap_req;
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_scan_fixed();
        test_pwm();
        test_swap_midframe();
        test_abort();
        test_swap_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
